mlp_seq_engine: RTL and testbench

- Parametrised, time-multiplexed two-layer perceptron: N_IN signed inputs, N_HID hidden neurons, one output neuron, step activation.
- Uses one shared multiply-accumulate unit sequenced by an FSM.
- Weights live in a writable register file. Samples enter and results leave on valid/ready handshakes.
- Sits between the sample source and the downstream classifier/control logic.

---
 rtl/mlp_seq_engine.sv | 151 +++++++++++++++
 tb/tb_mlp_seq_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed two-layer perceptron: one shared MAC walks the weight file in address order,
// first through the hidden layer (saturated to DW) and then through the single output neuron.
module mlp_seq_engine #(
  parameter int N_IN  = 2,
  parameter int N_HID = 3,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int AW    = 24,
  parameter int FRAC  = 0,
  localparam int NW   = N_HID * (N_IN + 1),
  localparam int ADW  = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_we,
  input  logic [ADW-1:0]     w_addr,
  input  logic [WW-1:0]      w_data,
  output logic               w_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*DW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_y,
  output logic               out_p
);

  localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state_reg, state_next;

  logic [N_IN*DW-1:0]      x_reg;
  logic signed [DW-1:0]    x_arr   [N_IN];
  logic signed [WW-1:0]    w_mem   [NW];
  logic signed [DW-1:0]    hid_reg [N_HID];
  logic [HW-1:0]           h_reg;
  logic [IW-1:0]           i_reg;
  logic [ADW-1:0]          wp_reg;
  logic signed [AW-1:0]    acc_reg;
  logic signed [DW-1:0]    mac_a;
  logic signed [DW+WW-1:0] prod;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    shifted;
  logic signed [DW-1:0]    hid_val;
  logic                    last_i, last_h, we_ok, accept;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign x_arr[gi] = x_reg[gi*DW +: DW];
  end

  assign last_i = (i_reg == IW'(N_IN - 1));
  assign last_h = (h_reg == HW'(N_HID - 1));
  assign accept = in_valid && in_ready;
  assign we_ok  = w_we && (state_reg == IDLE) && (32'(w_addr) < NW);

  // The weight pointer advances once per MAC, so L1 and L2 read the file strictly in address order.
  always_comb begin
    mac_a = (state_reg == L2) ? hid_reg[h_reg] : x_arr[i_reg];
    prod  = mac_a * w_mem[wp_reg];
    sum   = acc_reg + AW'(prod);
    shifted = sum >>> FRAC;
    if (shifted > AW'(SMAX))      hid_val = SMAX;
    else if (shifted < AW'(SMIN)) hid_val = SMIN;
    else                          hid_val = shifted[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)         state_next = L1;
      L1:   if (last_i && last_h) state_next = L2;
      L2:   if (last_h)           state_next = DONE;
      DONE: if (out_ready)        state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w_mem[k] <= '0;
      w_err <= 1'b0;
    end else begin
      w_err <= w_we && !we_ok;
      if (we_ok) w_mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      h_reg     <= '0;
      i_reg     <= '0;
      wp_reg    <= '0;
      acc_reg   <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_p     <= 1'b0;
      for (int k = 0; k < N_HID; k++) hid_reg[k] <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          x_reg   <= in_data;
          h_reg   <= '0;
          i_reg   <= '0;
          wp_reg  <= '0;
          acc_reg <= '0;
        end
        L1: begin
          wp_reg <= wp_reg + 1'b1;
          if (last_i) begin
            hid_reg[h_reg] <= hid_val;
            acc_reg <= '0;
            i_reg   <= '0;
            h_reg   <= last_h ? '0 : h_reg + 1'b1;
          end else begin
            acc_reg <= sum;
            i_reg   <= i_reg + 1'b1;
          end
        end
        L2: begin
          wp_reg <= wp_reg + 1'b1;
          if (last_h) begin
            out_y     <= sum;
            out_p     <= (sum > 0);
            out_valid <= 1'b1;
            acc_reg   <= '0;
          end else begin
            acc_reg <= sum;
            h_reg   <= h_reg + 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine: a plain-arithmetic model of the perceptron predicts every
// result, and a negedge compare process checks any valid output against it.
module tb_mlp_seq_engine;
  localparam int N_IN = 2, N_HID = 3, DW = 8, WW = 8, AW = 24, FRAC = 0;
  localparam int NW = N_HID * (N_IN + 1);
  localparam int ADW = 4;

  logic clk = 1'b0, rst_n = 1'b0, w_we = 1'b0, w_err, in_valid = 1'b0, in_ready;
  logic [ADW-1:0] w_addr = '0;
  logic [WW-1:0] w_data = '0;
  logic [N_IN*DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b0, out_p;
  logic signed [AW-1:0] out_y;

  int errors = 0, checks = 0;
  int wm [NW];
  longint exp_y = 0;
  logic exp_p = 1'b0;
  bit cmp_en = 1'b0;

  mlp_seq_engine #(.N_IN(N_IN), .N_HID(N_HID), .DW(DW), .WW(WW), .AW(AW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(w_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_p(out_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic longint model(input int x0, input int x1);
    longint xs [N_IN];
    longint s, hv, y;
    xs[0] = x0; xs[1] = x1; y = 0;
    for (int h = 0; h < N_HID; h++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += xs[i] * wm[h*N_IN + i];
      s = s >>> FRAC;
      hv = (s > 127) ? 127 : ((s < -128) ? -128 : s);
      y += hv * wm[N_HID*N_IN + h];
    end
    return y;
  endfunction

  always @(negedge clk) begin
    if (rst_n && cmp_en && out_valid) begin
      check("model_y", out_y, exp_y);
      check("model_p", out_p, exp_p);
      check("ready_busy", in_ready, 0);
    end
  end

  task automatic write_w(input int addr, input int data, input bit exp_err);
    @(negedge clk);
    w_we = 1'b1; w_addr = addr[ADW-1:0]; w_data = data[WW-1:0];
    @(posedge clk); #1;
    w_we = 1'b0;
    check("w_err_pulse", w_err, exp_err);
    if (!exp_err) wm[addr] = data;
    @(posedge clk); #1;
    check("w_err_clear", w_err, 0);
  endtask

  task automatic set_all(input int l1, input int l2);
    for (int a = 0; a < NW; a++) write_w(a, (a < N_HID*N_IN) ? l1 : l2, 1'b0);
  endtask

  task automatic run_sample(input int x0, input int x1, input int hold,
                            input longint lit_y, input bit lit_p, input bit busy_wr);
    int lat;
    bit done;
    exp_y = model(x0, x1);
    exp_p = (exp_y > 0);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data = {DW'(x1), DW'(x0)};
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (busy_wr) begin
      w_we = 1'b1; w_addr = '0; w_data = 8'h80;
    end
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_wr && lat == 1) begin
        check("w_err_busy", w_err, 1);
        w_we = 1'b0;
      end
      if (busy_wr && lat == 2) check("w_err_busy_clear", w_err, 0);
      if (out_valid) done = 1'b1;
    end
    if (!done) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, NW);
    check("lit_y", out_y, lit_y);
    check("lit_p", out_p, lit_p);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("ready_back", in_ready, 1);
    $display("sample x=(%0d,%0d) y=%0d p=%0d latency=%0d hold=%0d", x0, x1, exp_y, exp_p, lat, hold);
  endtask

  initial begin
    for (int a = 0; a < NW; a++) wm[a] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_p", out_p, 0);
    check("rst_w_err", w_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    set_all(1, 1);
    run_sample(1, 1, 0, 6, 1'b1, 1'b0);
    run_sample(-1, -1, 0, -6, 1'b0, 1'b0);
    write_w(0, -1, 1'b0);
    write_w(1, -1, 1'b0);
    run_sample(1, 1, 0, 2, 1'b1, 1'b0);

    set_all(127, 1);
    run_sample(127, 127, 0, 381, 1'b1, 1'b0);
    run_sample(-128, -128, 0, -384, 1'b0, 1'b0);

    set_all(1, 1);
    run_sample(1, 1, 20, 6, 1'b1, 1'b0);
    run_sample(1, 1, 0, 6, 1'b1, 1'b1);
    write_w(9, 5, 1'b1);
    run_sample(1, 1, 0, 6, 1'b1, 1'b0);
    set_all(0, 0);
    run_sample(5, -3, 0, 0, 1'b0, 1'b0);

    // Reset while the output layer is being accumulated.
    set_all(1, 1);
    exp_y = model(1, 1);
    exp_p = (exp_y > 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = {DW'(1), DW'(1)};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_y", out_y, 0);
    check("mid_rst_out_p", out_p, 0);
    check("mid_rst_in_ready", in_ready, 1);
    for (int a = 0; a < NW; a++) wm[a] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    $display("reset mid-L2 applied");
    run_sample(3, 4, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
